// File: rtl/seq_muldiv_if.sv
// seq_muldiv handshake bundle: start/busy/done plus operands and results.
// master drives requests, slave is the multiply/divide unit.
interface seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;
  logic             divZero;

  modport master (
    output start, op, a, b,
    input  busy, done, resHi, resLo, divZero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, resHi, resLo, divZero
  );
endinterface

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative shift-add multiplier / restoring divider, 1 bit/clk.
// Divider datapath only present when MULDIV_DIV_EN is defined.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   dsr;
  logic               is_div;
  logic               neg_p;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               div_zero;

  logic               accept;
  logic               skip;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign accept = bus.start & ((state == IDLE) | (state == DONE));

  assign a_mag = (bus.op[0] & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.op[0] & bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // hi:lo is the accumulator; lo holds the multiplier and shifts out LSB-first
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
  assign prod     = {hi, lo};
  assign prod_fix = neg_p ? -prod : prod;

`ifdef MULDIV_DIV_EN
  logic             neg_r;
  logic             dz;
  logic [WIDTH:0]   div_t;
  logic [WIDTH:0]   div_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign skip    = bus.op[1] & (bus.b == '0);
  // hi is the partial remainder, lo shifts dividend out / quotient in
  assign div_t   = {hi, lo[WIDTH-1]};
  assign div_d   = div_t - {1'b0, dsr};
  assign quo_fix = neg_p ? -lo : lo;
  assign rem_fix = neg_r ? -hi : hi;
`else
  // without a divider every divide request short-cuts straight to FIX
  assign skip = bus.op[1];
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = skip ? FIX : RUN;
      RUN:  if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: begin
        if (accept) state_nx = skip ? FIX : RUN;
        else        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, per-bit iteration and sign fix-up into result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      dsr      <= '0;
      is_div   <= 1'b0;
      neg_p    <= 1'b0;
      res_hi   <= '0;
      res_lo   <= '0;
      div_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r    <= 1'b0;
      dz       <= 1'b0;
`endif
    end else if (accept) begin
      cnt      <= CW'(WIDTH - 1);
      is_div   <= bus.op[1];
      neg_p    <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      lo       <= bus.op[1] ? a_mag : b_mag;
      dsr      <= bus.op[1] ? b_mag : a_mag;
      div_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r    <= bus.op[0] & bus.a[WIDTH-1];
      dz       <= skip;
      hi       <= skip ? bus.a : '0;
`else
      hi       <= '0;
`endif
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
`ifdef MULDIV_DIV_EN
      if (is_div) begin
        if (!div_d[WIDTH]) begin
          hi <= div_d[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= div_t[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end else if (state == FIX) begin
`ifdef MULDIV_DIV_EN
      if (dz) begin
        res_hi   <= hi;
        res_lo   <= '1;
        div_zero <= 1'b1;
      end else if (is_div) begin
        res_hi <= rem_fix;
        res_lo <= quo_fix;
      end else begin
        res_hi <= prod_fix[2*WIDTH-1:WIDTH];
        res_lo <= prod_fix[WIDTH-1:0];
      end
`else
      if (is_div) begin
        res_hi <= '0;
        res_lo <= '0;
      end else begin
        res_hi <= prod_fix[2*WIDTH-1:WIDTH];
        res_lo <= prod_fix[WIDTH-1:0];
      end
`endif
    end
  end

  assign bus.busy    = (state == RUN) | (state == FIX);
  assign bus.done    = (state == DONE);
  assign bus.resHi   = res_hi;
  assign bus.resLo   = res_lo;
  assign bus.divZero = div_zero;

endmodule
